// File: rtl/cosim_constants_pkg.sv
// -----------------------------------------------------------------------------
// cosim_constants_pkg
// Shared constants and types for the co-simulation commit log.
//   DPI_W                         : width of one stream word
//   LOG_REG_WRITE_ITEM_DPI_WORDS  : words per register-write item
//   LOG_MEM_ITEM_DPI_WORDS        : words per memory-read/write item
//   log_kind_e                    : item kind as seen on kind_o
//   log_fsm_e                     : serializer FSM state (exported for debug)
//   reg_item_t / mem_item_t       : packed item layouts, LSB = first word
// -----------------------------------------------------------------------------
package cosim_constants_pkg;

  localparam int DPI_W                        = 32;
  localparam int LOG_REG_WRITE_ITEM_DPI_WORDS = 4;
  localparam int LOG_MEM_ITEM_DPI_WORDS       = 5;

  localparam int REG_ITEM_W = LOG_REG_WRITE_ITEM_DPI_WORDS * DPI_W;
  localparam int MEM_ITEM_W = LOG_MEM_ITEM_DPI_WORDS * DPI_W;

  typedef enum logic [1:0] {
    LOG_REG_WRITE = 2'd0,
    LOG_MEM_READ  = 2'd1,
    LOG_MEM_WRITE = 2'd2
  } log_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } log_fsm_e;

  // Field order puts key/addr in the low bits so they leave first.
  typedef struct packed {
    logic [63:0] data;
    logic [63:0] key;
  } reg_item_t;

  typedef struct packed {
    logic [7:0]  size;
    logic [63:0] data;
    logic [63:0] addr;
  } mem_item_t;

  // Number of stream words an item of the given kind occupies.
  function automatic logic [2:0] item_words(input log_kind_e kind);
    logic [2:0] n;
    n = 3'(LOG_MEM_ITEM_DPI_WORDS);
    if (kind == LOG_REG_WRITE) n = 3'(LOG_REG_WRITE_ITEM_DPI_WORDS);
    return n;
  endfunction

  // Word idx of a register-write item, zero-padded past the struct.
  function automatic logic [DPI_W-1:0] reg_item_word(input reg_item_t item,
                                                     input logic [2:0] idx);
    logic [REG_ITEM_W-1:0] flat;
    logic [DPI_W-1:0]      w;
    flat = REG_ITEM_W'(item);
    w    = '0;
    for (int i = 0; i < LOG_REG_WRITE_ITEM_DPI_WORDS; i++) begin
      if (idx == 3'(i)) w = flat[i*DPI_W +: DPI_W];
    end
    return w;
  endfunction

  // Word idx of a memory item; the size byte lands in the last word.
  function automatic logic [DPI_W-1:0] mem_item_word(input mem_item_t item,
                                                     input logic [2:0] idx);
    logic [MEM_ITEM_W-1:0] flat;
    logic [DPI_W-1:0]      w;
    flat = MEM_ITEM_W'(item);
    w    = '0;
    for (int i = 0; i < LOG_MEM_ITEM_DPI_WORDS; i++) begin
      if (idx == 3'(i)) w = flat[i*DPI_W +: DPI_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/cosim_log_fifo.sv
// -----------------------------------------------------------------------------
// cosim_log_fifo
// Synchronous FIFO with first-word-fall-through read port.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write request; accepted when not full, or when full and
//                  popping in the same cycle
//   pop_i        : remove head (ignored when empty)
//   data_o       : current head (valid while empty_o is low)
//   full_o/empty_o
// -----------------------------------------------------------------------------
module cosim_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  // A full FIFO that is popping this cycle frees a slot in time for the push.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cosim_commit_log_serializer.sv
// -----------------------------------------------------------------------------
// cosim_commit_log_serializer
// Buffers register-write / memory-read / memory-write retire events in three
// FIFOs and emits them one item at a time as a stream of DPI_W-bit words.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   rw_* / mr_* / mw_*        : event capture inputs, one FIFO per kind
//   word_valid_o/word_ready_i : output stream handshake
//   word_o, kind_o, last_o    : current word, its item kind, last-word flag
//   hart_o                    : constant HART_ID
//   overflow_o                : sticky per-kind drop flag (bit = kind)
//   *_count_o                 : items fully emitted per kind (wrap at 2^32)
//   dbg_state_o               : FSM state, for observation only
//
// Stream handshake: a word transfers on every rising edge where word_valid_o
// and word_ready_i are both high. Once word_valid_o is high, word_o, kind_o
// and last_o hold until that transfer; word_valid_o never depends on
// word_ready_i.
// -----------------------------------------------------------------------------
module cosim_commit_log_serializer
  import cosim_constants_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HART_ID = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rw_valid_i,
  input  logic [63:0]      rw_key_i,
  input  logic [63:0]      rw_data_i,
  input  logic             mr_valid_i,
  input  logic             mw_valid_i,
  input  logic [63:0]      mr_addr_i,
  input  logic [63:0]      mw_addr_i,
  input  logic [63:0]      mr_data_i,
  input  logic [63:0]      mw_data_i,
  input  logic [7:0]       mr_size_i,
  input  logic [7:0]       mw_size_i,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [DPI_W-1:0] word_o,
  output logic [1:0]       kind_o,
  output logic             last_o,
  output logic [31:0]      hart_o,
  output logic [2:0]       overflow_o,
  output logic [31:0]      rw_count_o,
  output logic [31:0]      mr_count_o,
  output logic [31:0]      mw_count_o,
  output log_fsm_e         dbg_state_o
);

  // ---------------------------------------------------------------------------
  // Per-kind FIFOs
  // ---------------------------------------------------------------------------
  reg_item_t w_rw_in, w_rw_head;
  mem_item_t w_mr_in, w_mr_head;
  mem_item_t w_mw_in, w_mw_head;
  logic      w_rw_full, w_rw_empty, w_rw_pop;
  logic      w_mr_full, w_mr_empty, w_mr_pop;
  logic      w_mw_full, w_mw_empty, w_mw_pop;

  assign w_rw_in = '{data: rw_data_i, key: rw_key_i};
  assign w_mr_in = '{size: mr_size_i, data: mr_data_i, addr: mr_addr_i};
  assign w_mw_in = '{size: mw_size_i, data: mw_data_i, addr: mw_addr_i};

  cosim_log_fifo #(.WIDTH($bits(reg_item_t)), .DEPTH(DEPTH)) u_rw_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (rw_valid_i),
    .data_i (w_rw_in),
    .pop_i  (w_rw_pop),
    .data_o (w_rw_head),
    .full_o (w_rw_full),
    .empty_o(w_rw_empty)
  );

  cosim_log_fifo #(.WIDTH($bits(mem_item_t)), .DEPTH(DEPTH)) u_mr_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (mr_valid_i),
    .data_i (w_mr_in),
    .pop_i  (w_mr_pop),
    .data_o (w_mr_head),
    .full_o (w_mr_full),
    .empty_o(w_mr_empty)
  );

  cosim_log_fifo #(.WIDTH($bits(mem_item_t)), .DEPTH(DEPTH)) u_mw_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (mw_valid_i),
    .data_i (w_mw_in),
    .pop_i  (w_mw_pop),
    .data_o (w_mw_head),
    .full_o (w_mw_full),
    .empty_o(w_mw_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbiter / word selection
  // ---------------------------------------------------------------------------
  log_fsm_e   r_state;
  log_kind_e  r_kind;
  logic [2:0] r_idx;

  logic       w_hs;
  logic       w_item_done;
  logic       w_any_pending;
  logic [2:0] w_drop;
  log_kind_e  w_sel_kind;
  logic [2:0] w_sel_idx;
  logic [2:0] w_item_words;
  logic [DPI_W-1:0] w_sel_word;

  assign w_hs          = word_valid_o && word_ready_i;
  assign w_item_done   = (r_state == ST_SEND) && w_hs && last_o;
  assign w_any_pending = !(w_rw_empty && w_mr_empty && w_mw_empty);

  // The head is popped in the final-handshake cycle so the FIFO and counter
  // both update on the same edge.
  assign w_rw_pop = w_item_done && (r_kind == LOG_REG_WRITE);
  assign w_mr_pop = w_item_done && (r_kind == LOG_MEM_READ);
  assign w_mw_pop = w_item_done && (r_kind == LOG_MEM_WRITE);

  // Mirrors the FIFO accept rule: full and not popping means dropped.
  assign w_drop[0] = rw_valid_i && w_rw_full && !w_rw_pop;
  assign w_drop[1] = mr_valid_i && w_mr_full && !w_mr_pop;
  assign w_drop[2] = mw_valid_i && w_mw_full && !w_mw_pop;

  // In IDLE this picks the next item's first word; in SEND it prepares the
  // word that follows the one currently presented.
  always_comb begin
    w_sel_kind = r_kind;
    w_sel_idx  = r_idx + 3'd1;
    if (r_state == ST_IDLE) begin
      w_sel_idx = 3'd0;
      if (!w_rw_empty)      w_sel_kind = LOG_REG_WRITE;
      else if (!w_mr_empty) w_sel_kind = LOG_MEM_READ;
      else                  w_sel_kind = LOG_MEM_WRITE;
    end
    w_item_words = item_words(w_sel_kind);
    w_sel_word   = '0;
    case (w_sel_kind)
      LOG_REG_WRITE: w_sel_word = reg_item_word(w_rw_head, w_sel_idx);
      LOG_MEM_READ:  w_sel_word = mem_item_word(w_mr_head, w_sel_idx);
      LOG_MEM_WRITE: w_sel_word = mem_item_word(w_mw_head, w_sel_idx);
      default:       w_sel_word = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM with registered stream outputs, counters and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_kind       <= LOG_REG_WRITE;
      r_idx        <= 3'd0;
      word_valid_o <= 1'b0;
      word_o       <= '0;
      kind_o       <= 2'd0;
      last_o       <= 1'b0;
      overflow_o   <= 3'b000;
      rw_count_o   <= 32'd0;
      mr_count_o   <= 32'd0;
      mw_count_o   <= 32'd0;
    end else begin
      overflow_o <= overflow_o | w_drop;
      case (r_state)
        ST_IDLE: begin
          if (w_any_pending) begin
            r_state      <= ST_SEND;
            r_kind       <= w_sel_kind;
            r_idx        <= 3'd0;
            word_valid_o <= 1'b1;
            word_o       <= w_sel_word;
            kind_o       <= w_sel_kind;
            last_o       <= (w_item_words == 3'd1);
          end
        end
        ST_SEND: begin
          if (w_hs) begin
            if (last_o) begin
              r_state      <= ST_IDLE;
              word_valid_o <= 1'b0;
              word_o       <= '0;
              kind_o       <= 2'd0;
              last_o       <= 1'b0;
              case (r_kind)
                LOG_REG_WRITE: rw_count_o <= rw_count_o + 32'd1;
                LOG_MEM_READ:  mr_count_o <= mr_count_o + 32'd1;
                LOG_MEM_WRITE: mw_count_o <= mw_count_o + 32'd1;
                default:       ;
              endcase
            end else begin
              r_idx  <= w_sel_idx;
              word_o <= w_sel_word;
              last_o <= (w_sel_idx == w_item_words - 3'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign hart_o      = 32'(HART_ID);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_cosim_commit_log_serializer.sv
module tb_cosim_commit_log_serializer;

  localparam int TB_DEPTH = 4;
  localparam int TB_HART  = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic        rw_valid_i, mr_valid_i, mw_valid_i;
  logic [63:0] rw_key_i, rw_data_i;
  logic [63:0] mr_addr_i, mw_addr_i, mr_data_i, mw_data_i;
  logic [7:0]  mr_size_i, mw_size_i;
  logic        word_valid_o, word_ready_i, last_o;
  logic [31:0] word_o, hart_o, rw_count_o, mr_count_o, mw_count_o;
  logic [1:0]  kind_o;
  logic [2:0]  overflow_o;
  logic        dbg_state;

  cosim_commit_log_serializer #(.DEPTH(TB_DEPTH), .HART_ID(TB_HART)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rw_valid_i  (rw_valid_i),
    .rw_key_i    (rw_key_i),
    .rw_data_i   (rw_data_i),
    .mr_valid_i  (mr_valid_i),
    .mw_valid_i  (mw_valid_i),
    .mr_addr_i   (mr_addr_i),
    .mw_addr_i   (mw_addr_i),
    .mr_data_i   (mr_data_i),
    .mw_data_i   (mw_data_i),
    .mr_size_i   (mr_size_i),
    .mw_size_i   (mw_size_i),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .word_o      (word_o),
    .kind_o      (kind_o),
    .last_o      (last_o),
    .hart_o      (hart_o),
    .overflow_o  (overflow_o),
    .rw_count_o  (rw_count_o),
    .mr_count_o  (mr_count_o),
    .mw_count_o  (mw_count_o),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: item images built straight from the documented layouts
  // ---------------------------------------------------------------------------
  function automatic logic [159:0] exp_reg(input logic [63:0] key, input logic [63:0] data);
    logic [159:0] v;
    v = '0;
    v[31:0]   = key[31:0];
    v[63:32]  = key[63:32];
    v[95:64]  = data[31:0];
    v[127:96] = data[63:32];
    return v;
  endfunction

  function automatic logic [159:0] exp_mem(input logic [63:0] addr, input logic [63:0] data,
                                           input logic [7:0] size);
    logic [159:0] v;
    v = '0;
    v[31:0]    = addr[31:0];
    v[63:32]   = addr[63:32];
    v[95:64]   = data[31:0];
    v[127:96]  = data[63:32];
    v[159:128] = {24'h0, size};
    return v;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Output monitor: assembles handshaken words into items
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]   kind;
    logic [159:0] bits;
    int           n;
    bit           kind_changed;
    int           first_cyc;
    int           last_cyc;
  } obs_item_t;

  obs_item_t    obs_q[$];
  obs_item_t    cur;
  int           cur_n = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      cur_n = 0;
    end else if (word_valid_o && word_ready_i) begin
      if (cur_n == 0) begin
        cur.kind = kind_o;
        cur.bits = '0;
        cur.kind_changed = 1'b0;
        cur.first_cyc = cyc;
      end else if (kind_o !== cur.kind) begin
        cur.kind_changed = 1'b1;
      end
      if (cur_n < 5) cur.bits[cur_n*32 +: 32] = word_o;
      cur_n = cur_n + 1;
      if (last_o) begin
        cur.n = cur_n;
        cur.last_cyc = cyc;
        obs_q.push_back(cur);
        cur_n = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) word_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_inputs();
    rw_valid_i = 0; mr_valid_i = 0; mw_valid_i = 0;
    rw_key_i = '0; rw_data_i = '0;
    mr_addr_i = '0; mr_data_i = '0; mr_size_i = '0;
    mw_addr_i = '0; mw_data_i = '0; mw_size_i = '0;
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    word_ready_i = 1'b1;
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    obs_q.delete();
  endtask

  task automatic wait_items(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (obs_q.size() < n) begin
      n_fails++;
      $display("FAIL %s_wait: got %0d items, required %0d", name, obs_q.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (word_valid_o !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (word_valid_o !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_valid: word_valid_o=%b, required 1", name, word_valid_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks += 9;
    if (word_valid_o !== 1'b0) begin n_fails++; $display("FAIL rst_valid: %b vs 0", word_valid_o); end
    if (word_o !== 32'h0)      begin n_fails++; $display("FAIL rst_word: %h vs 0", word_o); end
    if (kind_o !== 2'd0)       begin n_fails++; $display("FAIL rst_kind: %0d vs 0", kind_o); end
    if (last_o !== 1'b0)       begin n_fails++; $display("FAIL rst_last: %b vs 0", last_o); end
    if (overflow_o !== 3'b000) begin n_fails++; $display("FAIL rst_ovf: %b vs 000", overflow_o); end
    if (rw_count_o !== 32'd0)  begin n_fails++; $display("FAIL rst_rwcnt: %0d vs 0", rw_count_o); end
    if (mr_count_o !== 32'd0)  begin n_fails++; $display("FAIL rst_mrcnt: %0d vs 0", mr_count_o); end
    if (mw_count_o !== 32'd0)  begin n_fails++; $display("FAIL rst_mwcnt: %0d vs 0", mw_count_o); end
    if (hart_o !== 32'(TB_HART)) begin n_fails++; $display("FAIL hart: %0d vs %0d", hart_o, TB_HART); end
  endtask

  task automatic test_single_reg();
    logic [31:0] ew [4];
    ew[0] = 32'h5; ew[1] = 32'h0; ew[2] = 32'h55667788; ew[3] = 32'h11223344;
    do_reset();
    rw_valid_i = 1; rw_key_i = 64'h5; rw_data_i = 64'h1122334455667788;
    tick();
    clear_inputs();
    n_checks++;
    if (word_valid_o !== 1'b0) begin n_fails++; $display("FAIL single_early: valid=%b vs 0", word_valid_o); end
    tick();
    n_checks += 4;
    if (word_valid_o !== 1'b1) begin n_fails++; $display("FAIL single_lat: valid=%b vs 1", word_valid_o); end
    if (word_o !== 32'h5)      begin n_fails++; $display("FAIL single_w0: %h vs 5", word_o); end
    if (kind_o !== 2'd0)       begin n_fails++; $display("FAIL single_kind: %0d vs 0", kind_o); end
    if (last_o !== 1'b0)       begin n_fails++; $display("FAIL single_last0: %b vs 0", last_o); end
    wait_items(1, 20, "single");
    tick();
    tick();
    if (obs_q.size() >= 1) begin
      n_checks += 2;
      if (obs_q[0].n !== 4) begin n_fails++; $display("FAIL single_len: %0d words vs 4", obs_q[0].n); end
      if (obs_q[0].last_cyc - obs_q[0].first_cyc !== 3) begin
        n_fails++; $display("FAIL single_dur: %0d vs 3", obs_q[0].last_cyc - obs_q[0].first_cyc);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[0].bits[i*32 +: 32] !== ew[i]) begin
          n_fails++; $display("FAIL single_word%0d: %h vs %h", i, obs_q[0].bits[i*32 +: 32], ew[i]);
        end
      end
    end
    n_checks += 2;
    if (rw_count_o !== 32'd1) begin n_fails++; $display("FAIL single_cnt: %0d vs 1", rw_count_o); end
    if (mw_count_o !== 32'd0) begin n_fails++; $display("FAIL single_mwcnt: %0d vs 0", mw_count_o); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] k0, d0, k1, d1;
    do_reset();
    k0 = r64(); d0 = r64(); k1 = r64(); d1 = r64();
    rw_valid_i = 1; rw_key_i = k0; rw_data_i = d0;
    tick();
    rw_key_i = k1; rw_data_i = d1;
    tick();
    clear_inputs();
    wait_items(2, 30, "b2b");
    tick();
    if (obs_q.size() >= 2) begin
      n_checks += 3;
      if (obs_q[0].bits !== exp_reg(k0, d0)) begin n_fails++; $display("FAIL b2b_item0: %h vs %h", obs_q[0].bits, exp_reg(k0, d0)); end
      if (obs_q[1].bits !== exp_reg(k1, d1)) begin n_fails++; $display("FAIL b2b_item1: %h vs %h", obs_q[1].bits, exp_reg(k1, d1)); end
      if (obs_q[1].first_cyc - obs_q[0].last_cyc !== 2) begin
        n_fails++; $display("FAIL b2b_gap: %0d vs 2", obs_q[1].first_cyc - obs_q[0].last_cyc);
      end
    end
    n_checks++;
    if (rw_count_o !== 32'd2) begin n_fails++; $display("FAIL b2b_cnt: %0d vs 2", rw_count_o); end
  endtask

  task automatic test_all_three();
    logic [159:0] e [3];
    do_reset();
    rw_valid_i = 1; rw_key_i = r64(); rw_data_i = r64();
    mr_valid_i = 1; mr_addr_i = r64(); mr_data_i = r64(); mr_size_i = 8'($urandom_range(1, 8));
    mw_valid_i = 1; mw_addr_i = r64(); mw_data_i = r64(); mw_size_i = 8'($urandom_range(1, 8));
    e[0] = exp_reg(rw_key_i, rw_data_i);
    e[1] = exp_mem(mr_addr_i, mr_data_i, mr_size_i);
    e[2] = exp_mem(mw_addr_i, mw_data_i, mw_size_i);
    tick();
    clear_inputs();
    wait_items(3, 40, "all3");
    tick();
    if (obs_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks += 3;
        if (obs_q[i].kind !== 2'(i)) begin n_fails++; $display("FAIL all3_kind%0d: %0d vs %0d", i, obs_q[i].kind, i); end
        if (obs_q[i].bits !== e[i]) begin n_fails++; $display("FAIL all3_item%0d: %h vs %h", i, obs_q[i].bits, e[i]); end
        if (obs_q[i].kind_changed) begin n_fails++; $display("FAIL all3_interleave%0d: kind changed vs stable", i); end
      end
    end
    n_checks += 3;
    if (rw_count_o !== 32'd1) begin n_fails++; $display("FAIL all3_rwcnt: %0d vs 1", rw_count_o); end
    if (mr_count_o !== 32'd1) begin n_fails++; $display("FAIL all3_mrcnt: %0d vs 1", mr_count_o); end
    if (mw_count_o !== 32'd1) begin n_fails++; $display("FAIL all3_mwcnt: %0d vs 1", mw_count_o); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, d;
    logic [7:0]  s;
    do_reset();
    a = r64(); d = r64(); s = 8'($urandom_range(1, 8));
    mr_valid_i = 1; mr_addr_i = a; mr_data_i = d; mr_size_i = s;
    tick();
    clear_inputs();
    wait_valid(10, "bp");
    tick();
    word_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks += 4;
      if (word_valid_o !== 1'b1)  begin n_fails++; $display("FAIL bp_valid%0d: %b vs 1", i, word_valid_o); end
      if (word_o !== a[63:32])    begin n_fails++; $display("FAIL bp_word%0d: %h vs %h", i, word_o, a[63:32]); end
      if (kind_o !== 2'd1)        begin n_fails++; $display("FAIL bp_kind%0d: %0d vs 1", i, kind_o); end
      if (last_o !== 1'b0)        begin n_fails++; $display("FAIL bp_last%0d: %b vs 0", i, last_o); end
      tick();
    end
    word_ready_i = 1'b1;
    wait_items(1, 20, "bp");
    tick();
    if (obs_q.size() >= 1) begin
      n_checks += 2;
      if (obs_q[0].bits !== exp_mem(a, d, s)) begin n_fails++; $display("FAIL bp_item: %h vs %h", obs_q[0].bits, exp_mem(a, d, s)); end
      if (obs_q[0].n !== 5) begin n_fails++; $display("FAIL bp_len: %0d vs 5", obs_q[0].n); end
    end
    n_checks++;
    if (mr_count_o !== 32'd1) begin n_fails++; $display("FAIL bp_cnt: %0d vs 1", mr_count_o); end
  endtask

  task automatic test_overflow();
    logic [159:0] exp_q[$];
    do_reset();
    word_ready_i = 1'b0;
    for (int i = 0; i < TB_DEPTH + 2; i++) begin
      mw_valid_i = 1; mw_addr_i = 64'h1000 + 64'(i); mw_data_i = r64(); mw_size_i = 8'd4;
      if (i < TB_DEPTH) exp_q.push_back(exp_mem(mw_addr_i, mw_data_i, mw_size_i));
      tick();
    end
    clear_inputs();
    tick();
    n_checks += 2;
    if (overflow_o !== 3'b100) begin n_fails++; $display("FAIL ovf_flag: %b vs 100", overflow_o); end
    if (mw_count_o !== 32'd0)  begin n_fails++; $display("FAIL ovf_cnt0: %0d vs 0", mw_count_o); end
    word_ready_i = 1'b1;
    wait_items(TB_DEPTH, 200, "ovf");
    for (int i = 0; i < 20; i++) tick();
    n_checks += 3;
    if (obs_q.size() !== TB_DEPTH) begin n_fails++; $display("FAIL ovf_items: %0d vs %0d", obs_q.size(), TB_DEPTH); end
    if (mw_count_o !== 32'(TB_DEPTH)) begin n_fails++; $display("FAIL ovf_cnt: %0d vs %0d", mw_count_o, TB_DEPTH); end
    if (overflow_o !== 3'b100) begin n_fails++; $display("FAIL ovf_sticky: %b vs 100", overflow_o); end
    for (int i = 0; i < obs_q.size() && i < TB_DEPTH; i++) begin
      n_checks++;
      if (obs_q[i].bits !== exp_q[i]) begin n_fails++; $display("FAIL ovf_item%0d: %h vs %h", i, obs_q[i].bits, exp_q[i]); end
    end
  endtask

  task automatic test_no_preempt();
    logic [159:0] e_mw, e_mr;
    do_reset();
    mw_valid_i = 1; mw_addr_i = r64(); mw_data_i = r64(); mw_size_i = 8'd8;
    e_mw = exp_mem(mw_addr_i, mw_data_i, mw_size_i);
    tick();
    clear_inputs();
    wait_valid(10, "npe");
    mr_valid_i = 1; mr_addr_i = r64(); mr_data_i = r64(); mr_size_i = 8'd2;
    e_mr = exp_mem(mr_addr_i, mr_data_i, mr_size_i);
    tick();
    clear_inputs();
    wait_items(2, 40, "npe");
    if (obs_q.size() >= 2) begin
      n_checks += 5;
      if (obs_q[0].kind !== 2'd2) begin n_fails++; $display("FAIL npe_kind0: %0d vs 2", obs_q[0].kind); end
      if (obs_q[1].kind !== 2'd1) begin n_fails++; $display("FAIL npe_kind1: %0d vs 1", obs_q[1].kind); end
      if (obs_q[0].bits !== e_mw) begin n_fails++; $display("FAIL npe_item0: %h vs %h", obs_q[0].bits, e_mw); end
      if (obs_q[1].bits !== e_mr) begin n_fails++; $display("FAIL npe_item1: %h vs %h", obs_q[1].bits, e_mr); end
      if (obs_q[0].kind_changed) begin n_fails++; $display("FAIL npe_interleave: kind changed vs stable"); end
    end
  endtask

  task automatic test_reset_mid_item();
    logic [63:0] k, d;
    do_reset();
    rw_valid_i = 1; rw_key_i = r64(); rw_data_i = r64();
    tick();
    clear_inputs();
    wait_valid(10, "rmid");
    tick();
    word_ready_i = 1'b0;
    mw_valid_i = 1; mw_addr_i = r64(); mw_data_i = r64(); mw_size_i = 8'd1;
    tick();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    n_checks += 7;
    if (word_valid_o !== 1'b0) begin n_fails++; $display("FAIL rmid_valid: %b vs 0", word_valid_o); end
    if (word_o !== 32'h0)      begin n_fails++; $display("FAIL rmid_word: %h vs 0", word_o); end
    if (kind_o !== 2'd0)       begin n_fails++; $display("FAIL rmid_kind: %0d vs 0", kind_o); end
    if (last_o !== 1'b0)       begin n_fails++; $display("FAIL rmid_last: %b vs 0", last_o); end
    if (overflow_o !== 3'b000) begin n_fails++; $display("FAIL rmid_ovf: %b vs 000", overflow_o); end
    if (rw_count_o !== 32'd0)  begin n_fails++; $display("FAIL rmid_rwcnt: %0d vs 0", rw_count_o); end
    if (mw_count_o !== 32'd0)  begin n_fails++; $display("FAIL rmid_mwcnt: %0d vs 0", mw_count_o); end
    rst_i = 1'b0;
    word_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (obs_q.size() !== 0) begin n_fails++; $display("FAIL rmid_stale: %0d items vs 0", obs_q.size()); end
    k = r64(); d = r64();
    rw_valid_i = 1; rw_key_i = k; rw_data_i = d;
    tick();
    clear_inputs();
    wait_items(1, 20, "rmid_new");
    tick();
    n_checks += 2;
    if (obs_q.size() !== 1) begin n_fails++; $display("FAIL rmid_newcount: %0d vs 1", obs_q.size()); end
    else if (obs_q[0].bits !== exp_reg(k, d)) begin n_fails++; $display("FAIL rmid_newitem: %h vs %h", obs_q[0].bits, exp_reg(k, d)); end
    if (rw_count_o !== 32'd1) begin n_fails++; $display("FAIL rmid_newcnt: %0d vs 1", rw_count_o); end
  endtask

  task automatic test_random();
    logic [159:0] exp_rw_q[$], exp_mr_q[$], exp_mw_q[$];
    logic [159:0] e;
    int total, n_rw, n_mr, n_mw;
    int c_rw, c_mr, c_mw;
    do_reset();
    rand_ready = 1'b1;
    total = 0; n_rw = 0; n_mr = 0; n_mw = 0;
    for (int b = 0; b < 6; b++) begin
      c_rw = 0; c_mr = 0; c_mw = 0;
      for (int c = 0; c < 10; c++) begin
        if ($urandom_range(0, 2) == 0 && c_rw < TB_DEPTH) begin
          rw_valid_i = 1; rw_key_i = r64(); rw_data_i = r64();
          exp_rw_q.push_back(exp_reg(rw_key_i, rw_data_i)); c_rw++;
        end
        if ($urandom_range(0, 2) == 0 && c_mr < TB_DEPTH) begin
          mr_valid_i = 1; mr_addr_i = r64(); mr_data_i = r64(); mr_size_i = 8'($urandom_range(0, 255));
          exp_mr_q.push_back(exp_mem(mr_addr_i, mr_data_i, mr_size_i)); c_mr++;
        end
        if ($urandom_range(0, 2) == 0 && c_mw < TB_DEPTH) begin
          mw_valid_i = 1; mw_addr_i = r64(); mw_data_i = r64(); mw_size_i = 8'($urandom_range(0, 255));
          exp_mw_q.push_back(exp_mem(mw_addr_i, mw_data_i, mw_size_i)); c_mw++;
        end
        tick();
        clear_inputs();
      end
      n_rw += c_rw; n_mr += c_mr; n_mw += c_mw;
      total += c_rw + c_mr + c_mw;
      wait_items(total, 600, "rand");
    end
    rand_ready = 1'b0;
    word_ready_i = 1'b1;
    tick();
    tick();
    foreach (obs_q[i]) begin
      n_checks += 2;
      if (obs_q[i].kind_changed) begin n_fails++; $display("FAIL rand_interleave%0d: kind changed vs stable", i); end
      case (obs_q[i].kind)
        2'd0: begin
          if (obs_q[i].n !== 4) begin n_fails++; $display("FAIL rand_len%0d: %0d vs 4", i, obs_q[i].n); end
          e = (exp_rw_q.size() > 0) ? exp_rw_q.pop_front() : '1;
        end
        2'd1: begin
          if (obs_q[i].n !== 5) begin n_fails++; $display("FAIL rand_len%0d: %0d vs 5", i, obs_q[i].n); end
          e = (exp_mr_q.size() > 0) ? exp_mr_q.pop_front() : '1;
        end
        default: begin
          if (obs_q[i].n !== 5) begin n_fails++; $display("FAIL rand_len%0d: %0d vs 5", i, obs_q[i].n); end
          e = (exp_mw_q.size() > 0) ? exp_mw_q.pop_front() : '1;
        end
      endcase
      n_checks++;
      if (obs_q[i].bits !== e) begin n_fails++; $display("FAIL rand_item%0d: kind %0d %h vs %h", i, obs_q[i].kind, obs_q[i].bits, e); end
    end
    n_checks += 5;
    if (exp_rw_q.size() + exp_mr_q.size() + exp_mw_q.size() !== 0) begin
      n_fails++; $display("FAIL rand_leftover: %0d items vs 0", exp_rw_q.size() + exp_mr_q.size() + exp_mw_q.size());
    end
    if (rw_count_o !== 32'(n_rw)) begin n_fails++; $display("FAIL rand_rwcnt: %0d vs %0d", rw_count_o, n_rw); end
    if (mr_count_o !== 32'(n_mr)) begin n_fails++; $display("FAIL rand_mrcnt: %0d vs %0d", mr_count_o, n_mr); end
    if (mw_count_o !== 32'(n_mw)) begin n_fails++; $display("FAIL rand_mwcnt: %0d vs %0d", mw_count_o, n_mw); end
    if (overflow_o !== 3'b000) begin n_fails++; $display("FAIL rand_ovf: %b vs 000", overflow_o); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    clear_inputs();
    word_ready_i = 1'b1;
    test_reset();
    test_single_reg();
    test_back_to_back();
    test_all_three();
    test_backpressure();
    test_overflow();
    test_no_preempt();
    test_reset_mid_item();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

endmodule
